// File: rtl/eeprom_boot_loader.sv
// eeprom_boot_loader: copies a fixed EEPROM image into program RAM after reset while
// holding the CPU in halt. Once the copy is done, it gives the EEPROM reader to CPU
// byte reads.
// Optional feature macro: EEPROM_BOOT_LOADER_CHECKSUM_EN. When defined, the loader
// reads one trailer byte after the image and flags a nonzero 8-bit sum.
//
// state   | meaning
// SYNC    | wait for the reader to go idle (it has no reset and may be mid-read)
// B_REQ   | boot copy: raise strobe
// B_ACK   | boot copy: hold strobe until ready drops, then drop strobe
// B_DATA  | boot copy: wait for ready high, capture byte
// B_WRITE | boot copy: RAM write strobe active, advance counters
// K_REQ   | checksum trailer: raise strobe (checksum build only)
// K_ACK   | checksum trailer: wait for acknowledge
// K_DATA  | checksum trailer: capture byte and compare the sum
// FINISH  | release the CPU and mark boot done
// SERVE   | wait for a CPU read request
// C_REQ   | CPU read: raise strobe
// C_ACK   | CPU read: wait for acknowledge
// C_DATA  | CPU read: capture byte, pulse cpu_ready
// C_GAP   | one idle clk so the requester can drop cpu_request
module eeprom_boot_loader #(
   parameter int unsigned LOAD_LENGTH = 1024,
   parameter logic [10:0] EEPROM_BASE = 11'd0,
   parameter logic [15:0] MEM_BASE    = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [10:0] eeprom_address,
   output logic        eeprom_strobe,
   input  logic        eeprom_ready,
   input  logic [7:0]  eeprom_data,
   output logic [15:0] mem_address,
   output logic [7:0]  mem_data,
   output logic        mem_write_enable,
   output logic        cpu_halt,
   output logic        boot_done,
   input  logic [10:0] cpu_address,
   input  logic        cpu_request,
   output logic [7:0]  cpu_data,
   output logic        cpu_ready,
   output logic        checksum_error
);
   typedef enum logic [3:0] {
      SYNC, B_REQ, B_ACK, B_DATA, B_WRITE,
`ifdef EEPROM_BOOT_LOADER_CHECKSUM_EN
      K_REQ, K_ACK, K_DATA,
`endif
      FINISH, SERVE, C_REQ, C_ACK, C_DATA, C_GAP
   } state_t;

   localparam logic [11:0] LEN = 12'(LOAD_LENGTH);

   state_t      state_q, state_d;
   logic [10:0] addr_q, addr_d;
   logic        strobe_q, strobe_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_data_q, mem_data_d;
   logic        mem_we_q, mem_we_d;
   logic        halt_q, halt_d;
   logic        done_q, done_d;
   logic [7:0]  cpu_data_q, cpu_data_d;
   logic        cpu_rdy_q, cpu_rdy_d;
   logic [11:0] count_q, count_d;
`ifdef EEPROM_BOOT_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q, sum_d;
   logic        chk_q, chk_d;
`endif

   // State and output registers; all outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SYNC;
         addr_q     <= EEPROM_BASE;
         strobe_q   <= 1'b0;
         mem_addr_q <= MEM_BASE;
         mem_data_q <= 8'h00;
         mem_we_q   <= 1'b0;
         halt_q     <= 1'b1;
         done_q     <= 1'b0;
         cpu_data_q <= 8'h00;
         cpu_rdy_q  <= 1'b0;
         count_q    <= 12'd0;
`ifdef EEPROM_BOOT_LOADER_CHECKSUM_EN
         sum_q      <= 8'h00;
         chk_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         strobe_q   <= strobe_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_we_q   <= mem_we_d;
         halt_q     <= halt_d;
         done_q     <= done_d;
         cpu_data_q <= cpu_data_d;
         cpu_rdy_q  <= cpu_rdy_d;
         count_q    <= count_d;
`ifdef EEPROM_BOOT_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
         chk_q      <= chk_d;
`endif
      end
   end

   // Next-state and next-output logic for the 4-phase reader handshake.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      strobe_d   = strobe_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_we_d   = 1'b0;
      halt_d     = halt_q;
      done_d     = done_q;
      cpu_data_d = cpu_data_q;
      cpu_rdy_d  = 1'b0;
      count_d    = count_q;
`ifdef EEPROM_BOOT_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
      chk_d      = chk_q;
`endif
      unique case (state_q)
         SYNC:    if (eeprom_ready) state_d = B_REQ;
         B_REQ:   begin strobe_d = 1'b1; state_d = B_ACK; end
         B_ACK:   if (!eeprom_ready) begin strobe_d = 1'b0; state_d = B_DATA; end
         B_DATA:  if (eeprom_ready) begin
                     mem_data_d = eeprom_data;
                     mem_addr_d = MEM_BASE + 16'(count_q);
                     mem_we_d   = 1'b1;
                     state_d    = B_WRITE;
                  end
         B_WRITE: begin
                     count_d = count_q + 12'd1;
                     addr_d  = addr_q + 11'd1;
`ifdef EEPROM_BOOT_LOADER_CHECKSUM_EN
                     sum_d   = sum_q + mem_data_q;
                     state_d = (count_q + 12'd1 == LEN) ? K_REQ : B_REQ;
`else
                     state_d = (count_q + 12'd1 == LEN) ? FINISH : B_REQ;
`endif
                  end
`ifdef EEPROM_BOOT_LOADER_CHECKSUM_EN
         K_REQ:   begin strobe_d = 1'b1; state_d = K_ACK; end
         K_ACK:   if (!eeprom_ready) begin strobe_d = 1'b0; state_d = K_DATA; end
         K_DATA:  if (eeprom_ready) begin
                     if (8'(sum_q + eeprom_data) != 8'h00) chk_d = 1'b1;
                     state_d = FINISH;
                  end
`endif
         FINISH:  begin halt_d = 1'b0; done_d = 1'b1; state_d = SERVE; end
         SERVE:   if (cpu_request) begin addr_d = cpu_address; state_d = C_REQ; end
         C_REQ:   begin strobe_d = 1'b1; state_d = C_ACK; end
         C_ACK:   if (!eeprom_ready) begin strobe_d = 1'b0; state_d = C_DATA; end
         C_DATA:  if (eeprom_ready) begin
                     cpu_data_d = eeprom_data;
                     cpu_rdy_d  = 1'b1;
                     state_d    = C_GAP;
                  end
         C_GAP:   state_d = SERVE;
         default: state_d = SYNC;
      endcase
   end

   assign eeprom_address   = addr_q;
   assign eeprom_strobe    = strobe_q;
   assign mem_address      = mem_addr_q;
   assign mem_data         = mem_data_q;
   assign mem_write_enable = mem_we_q;
   assign cpu_halt         = halt_q;
   assign boot_done        = done_q;
   assign cpu_data         = cpu_data_q;
   assign cpu_ready        = cpu_rdy_q;
`ifdef EEPROM_BOOT_LOADER_CHECKSUM_EN
   assign checksum_error   = chk_q;
`else
   assign checksum_error   = 1'b0;
`endif
endmodule

// File: doc/eeprom_boot_loader.md
Name: eeprom_boot_loader

Overview:
Sequences the serial EEPROM reader after reset. It copies a fixed image from EEPROM into program RAM, one byte per strobe/ready handshake, holding the CPU in halt until the copy completes. After boot it arbitrates the single EEPROM reader to CPU byte-read requests. It sits between the EEPROM reader (slow divided clock domain inside that block), the RAM write port and the CPU bus.

Parameters:
LOAD_LENGTH, 1024, number of bytes copied at boot (1..2048)
EEPROM_BASE, 0, first EEPROM byte address read (11-bit)
MEM_BASE, 16'h0000, first RAM address written

Ports:
clk  input  1  system clock (same clock that feeds the EEPROM reader's raw_clk)
reset  input  1  synchronous, active-high reset
eeprom_address  output  11  byte address presented to the EEPROM reader
eeprom_strobe  output  1  read request to the EEPROM reader
eeprom_ready  input  1  EEPROM reader idle/data-valid flag
eeprom_data  input  8  byte from the EEPROM reader
mem_address  output  16  RAM write address
mem_data  output  8  RAM write data
mem_write_enable  output  1  RAM write strobe, one clk wide
cpu_halt  output  1  holds CPU until boot copy finishes
boot_done  output  1  sticky, set when copy finishes
cpu_address  input  11  CPU EEPROM byte address
cpu_request  input  1  CPU read request (level, held until cpu_ready)
cpu_data  output  8  byte returned to CPU
cpu_ready  output  1  one clk pulse, cpu_data valid
checksum_error  output  1  see Optional Feature (tied 0 when compiled out)

Behaviour:
- Reset values: eeprom_strobe=0, eeprom_address=EEPROM_BASE, mem_write_enable=0, mem_address=MEM_BASE, mem_data=0, cpu_halt=1, boot_done=0, cpu_data=0, cpu_ready=0, checksum_error=0; byte counter=0; state=SYNC.
- Handshake with the EEPROM reader: the reader samples on a divided clock, so every transfer is 4-phase. (1) Assert strobe with address stable. (2) Hold strobe until eeprom_ready is seen low (acknowledge). (3) Drop strobe. (4) Wait for eeprom_ready high, then latch eeprom_data. Address is held constant from strobe assertion until the data is latched.
- States:
  SYNC: wait for eeprom_ready=1 (the reader has no reset and may be mid-read), then go to B_REQ.
  B_REQ: strobe=1 -> B_ACK.
  B_ACK: on ready=0, strobe=0 -> B_DATA.
  B_DATA: on ready=1, latch data -> B_WRITE.
  B_WRITE: mem_write_enable=1 for one clk, mem_data=byte, mem_address=MEM_BASE+count. Then increment count and eeprom_address (11-bit wrap 2047->0 permitted). If count reaches LOAD_LENGTH, go to FINISH; otherwise go to B_REQ.
  FINISH: cpu_halt=0, boot_done=1 -> SERVE.
  SERVE: on cpu_request, latch cpu_address -> C_REQ.
  C_REQ, C_ACK, C_DATA: same handshake as the boot path. On data, cpu_data=byte and cpu_ready=1 for one clk -> C_GAP.
  C_GAP: one idle clk so the requester can drop cpu_request -> SERVE.
- A cpu_request during boot is ignored until SERVE; cpu_ready stays 0.
- No RAM write occurs after boot; mem_write_enable=0 in all non-B_WRITE states.
- Reset mid-operation: all state returns to reset values, the copy restarts from byte 0, and SYNC prevents a new strobe while the reader is finishing an old read.
- Boot latency per byte is set by the reader (tens of divided-clock cycles); the controller adds at most 3 clk per byte.

Optional Feature:
EEPROM_BOOT_LOADER_CHECKSUM_EN
- Defined: the loader keeps an 8-bit wrapping sum of all copied bytes. After the last byte, it reads one extra EEPROM byte at EEPROM_BASE+LOAD_LENGTH (not written to RAM). If sum + extra byte != 8'h00, checksum_error=1 (sticky until reset). cpu_halt is still released and boot_done still set.
- Undefined: no extra read; checksum_error is constant 0.

Test Plan:
- EEPROM model holding pattern byte[i]=i^8'h5A, LOAD_LENGTH=16 -> exactly 16 mem writes at addresses 0..15 with data 5A,5B,58..., then cpu_halt falls and boot_done rises.
- Model delays ready-low acknowledge by 40 clk -> strobe held the full 40 clk, with no duplicate or missed byte.
- cpu_request asserted at cycle 10 (during boot) with cpu_address=11'h3FF -> no cpu_ready until after boot_done, then one cpu_ready pulse with cpu_data=model[0x3FF].
- Reset asserted mid-byte 7 while model ready=0 -> no strobe until model ready=1, then the copy restarts at address EEPROM_BASE and RAM 0.
- EEPROM_BASE=2040, LOAD_LENGTH=16 -> eeprom_address wraps 2047->0, and RAM addresses 0..15 are contiguous.
- CHECKSUM_EN, image 01,02,03 plus trailer FA -> checksum_error=0; trailer FB -> checksum_error=1 and boot_done=1.
